// File: rtl/pipeline_pkg.sv
// Shared opcode/funct/ALU constants and the control bundle carried through the pipeline.
package pipeline_pkg;

    localparam int CTRL_ALUC_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [CTRL_ALUC_W-1:0] ALU_ADD = 3'b010;
    localparam logic [CTRL_ALUC_W-1:0] ALU_SUB = 3'b110;
    localparam logic [CTRL_ALUC_W-1:0] ALU_AND = 3'b000;
    localparam logic [CTRL_ALUC_W-1:0] ALU_OR  = 3'b001;
    localparam logic [CTRL_ALUC_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                   reg_write;
        logic                   mem_to_reg;
        logic                   mem_write;
        logic                   branch;
        logic [CTRL_ALUC_W-1:0] alu_control;
        logic                   alu_src;
        logic                   reg_dst;
    } ctrl_t;

    // Instructions that read Rt as a source operand
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational D-stage decode of Opcode/Funct into the control bundle.
// Undefined encodings produce an all-zero (NOP) bundle and raise illegal.
module main_decoder
    import pipeline_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    FN_OR:   ctrl.alu_control = ALU_OR;
                    FN_SLT:  ctrl.alu_control = ALU_SLT;
                    default: begin
                        ctrl    = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipeline_controller.sv
// Control and hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
// Define FORWARDING_EN to add E-stage forwarding selects; only the load-use stall then remains.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int ALUC_W = CTRL_ALUC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic [5:0]        Funct,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
`ifdef FORWARDING_EN
    input  logic [REG_AW-1:0] RsE,
`endif
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              ZeroM,
    output logic              RegDstE,
    output logic              ALUSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              MemWriteM,
    output logic              PCSrcM,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
`ifdef FORWARDING_EN
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
`endif
    output logic              IllegalOp
);

    ctrl_t ctrl_d;
    logic  illegal_d;
    ctrl_t ctrl_e_reg;
    logic  reg_write_m_reg, mem_to_reg_m_reg, mem_write_m_reg, branch_m_reg;
    logic  reg_write_w_reg, mem_to_reg_w_reg;
    logic  illegal_reg;
    logic  pc_src, lw_stall, raw_stall, hazard, flush_e;

    main_decoder u_main_decoder (
        .opcode  (Opcode),
        .funct   (Funct),
        .ctrl    (ctrl_d),
        .illegal (illegal_d)
    );

    assign pc_src   = branch_m_reg & ZeroM;
    assign lw_stall = ctrl_e_reg.mem_to_reg & ctrl_e_reg.reg_write & (RtE != '0)
                    & ((RtE == RsD) | (RtE == RtD));

`ifdef FORWARDING_EN
    // M has priority over W because it holds the younger result
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic wr_m, input logic [REG_AW-1:0] dst_m,
                                           input logic wr_w, input logic [REG_AW-1:0] dst_w);
        if ((src != '0) && wr_m && (src == dst_m)) return 2'b10;
        if ((src != '0) && wr_w && (src == dst_w)) return 2'b01;
        return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(RsE, reg_write_m_reg, WriteRegM, reg_write_w_reg, WriteRegW);
    assign ForwardBE = fwd_sel(RtE, reg_write_m_reg, WriteRegM, reg_write_w_reg, WriteRegW);
    assign raw_stall = 1'b0;
`else
    logic [2:0]        stage_wr;
    logic [REG_AW-1:0] stage_dst [3];
    logic [2:0]        stage_hit;
    logic              rt_used;

    assign stage_wr     = {reg_write_w_reg, reg_write_m_reg, ctrl_e_reg.reg_write};
    assign stage_dst[0] = WriteRegE;
    assign stage_dst[1] = WriteRegM;
    assign stage_dst[2] = WriteRegW;
    assign rt_used      = reads_rt(Opcode);

    // Without bypass paths, D must wait until no older writer of its sources is in flight
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_raw
            assign stage_hit[gi] = stage_wr[gi] & (stage_dst[gi] != '0)
                                 & ((stage_dst[gi] == RsD) | (rt_used & (stage_dst[gi] == RtD)));
        end
    endgenerate
    assign raw_stall = |stage_hit;
`endif

    assign hazard  = lw_stall | raw_stall;
    assign flush_e = pc_src | hazard;

    assign StallF      = hazard & ~pc_src;
    assign StallD      = hazard & ~pc_src;
    assign FlushD      = pc_src;
    assign FlushE      = flush_e;
    assign PCSrcM      = pc_src;
    assign RegDstE     = ctrl_e_reg.reg_dst;
    assign ALUSrcE     = ctrl_e_reg.alu_src;
    assign ALUControlE = ALUC_W'(ctrl_e_reg.alu_control);
    assign MemWriteM   = mem_write_m_reg;
    assign RegWriteW   = reg_write_w_reg;
    assign MemToRegW   = mem_to_reg_w_reg;
    assign IllegalOp   = illegal_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_reg       <= '0;
            reg_write_m_reg  <= 1'b0;
            mem_to_reg_m_reg <= 1'b0;
            mem_write_m_reg  <= 1'b0;
            branch_m_reg     <= 1'b0;
            reg_write_w_reg  <= 1'b0;
            mem_to_reg_w_reg <= 1'b0;
            illegal_reg      <= 1'b0;
        end else begin
            ctrl_e_reg <= flush_e ? '0 : ctrl_d;
            // A taken branch kills the wrong-path instruction moving from E into M
            if (pc_src) begin
                reg_write_m_reg  <= 1'b0;
                mem_to_reg_m_reg <= 1'b0;
                mem_write_m_reg  <= 1'b0;
                branch_m_reg     <= 1'b0;
            end else begin
                reg_write_m_reg  <= ctrl_e_reg.reg_write;
                mem_to_reg_m_reg <= ctrl_e_reg.mem_to_reg;
                mem_write_m_reg  <= ctrl_e_reg.mem_write;
                branch_m_reg     <= ctrl_e_reg.branch;
            end
            reg_write_w_reg  <= reg_write_m_reg;
            mem_to_reg_w_reg <= mem_to_reg_m_reg;
            if (illegal_d) begin
                illegal_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized bench for pipeline_controller: the bench plays the datapath and tracks
// each instruction through E/M/W as records, deriving expected controls and hazards.
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic [4:0] RsD, RtD, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       ZeroM;
    logic       RegDstE, ALUSrcE, MemWriteM, PCSrcM, RegWriteW, MemToRegW;
    logic [2:0] ALUControlE;
    logic       StallF, StallD, FlushD, FlushE, IllegalOp;
`ifdef FORWARDING_EN
    logic [4:0] RsE;
    logic [1:0] ForwardAE, ForwardBE;
`endif

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .RsD(RsD), .RtD(RtD),
`ifdef FORWARDING_EN
        .RsE(RsE),
`endif
        .RtE(RtE), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .ZeroM(ZeroM), .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemWriteM(MemWriteM), .PCSrcM(PCSrcM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
`ifdef FORWARDING_EN
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`endif
        .IllegalOp(IllegalOp)
    );

    typedef struct packed {
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct packed {
        logic       rw, m2r, mw, br, src, dst, ill;
        logic [2:0] alu;
    } ctl_t;

    typedef struct packed {
        ctl_t       c;
        logic [4:0] rs, rt, dest;
        logic       zero;
    } stage_t;

    stage_t st_e, st_m, st_w;
    instr_t d;
    instr_t pend[$];
    bit     exp_ill, rnd_en;
    bit     nx_stall, nx_pcsrc, nx_flushe;
    int     n_total = 0, n_bad = 0, cyc = 0;

    // Control table for the supported instruction set
    function automatic ctl_t spec_ctl(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (op)
            6'b000000: begin
                c.rw = 1'b1; c.dst = 1'b1;
                case (fn)
                    6'b100000: c.alu = 3'b010;
                    6'b100010: c.alu = 3'b110;
                    6'b100100: c.alu = 3'b000;
                    6'b100101: c.alu = 3'b001;
                    6'b101010: c.alu = 3'b111;
                    default: begin c = '0; c.ill = 1'b1; end
                endcase
            end
            6'b100011: begin c.rw = 1'b1; c.src = 1'b1; c.m2r = 1'b1; c.alu = 3'b010; end
            6'b101011: begin c.mw = 1'b1; c.src = 1'b1; c.alu = 3'b010; end
            6'b000100: begin c.br = 1'b1; c.alu = 3'b110; end
            6'b001000: begin c.rw = 1'b1; c.src = 1'b1; c.alu = 3'b010; end
            default:   c.ill = 1'b1;
        endcase
        return c;
    endfunction

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        instr_t i;
        i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        logic [5:0] op, fn;
        int sel;
        sel = int'($urandom_range(0, 8));
        op  = 6'b000000;
        fn  = 6'b000000;
        case (sel)
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            5: op = 6'b100011;
            6: op = 6'b101011;
            7: op = 6'b000100;
            default: op = 6'b001000;
        endcase
        return mk(op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
    endfunction

    function automatic instr_t filler();
        return mk(6'b000000, 6'b100100, 5'd0, 5'd0, 5'd0);
    endfunction

    function automatic instr_t next_instr();
        if (pend.size() > 0) return pend.pop_front();
        if (rnd_en) return rnd_instr();
        return filler();
    endfunction

    function automatic bit hit(input stage_t s, input instr_t di, input bit ur);
        return s.c.rw && (s.dest != 5'd0) && ((s.dest == di.rs) || (ur && (s.dest == di.rt)));
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] src);
        if ((src != 5'd0) && st_m.c.rw && (st_m.dest == src)) return 2'b10;
        if ((src != 5'd0) && st_w.c.rw && (st_w.dest == src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        Opcode = d.op;  Funct = d.fn;  RsD = d.rs;  RtD = d.rt;
        RtE = st_e.rt;  WriteRegE = st_e.dest;  WriteRegM = st_m.dest;
        WriteRegW = st_w.dest;  ZeroM = st_m.zero;
`ifdef FORWARDING_EN
        RsE = st_e.rs;
`endif
    endtask

    task automatic clear_model();
        st_e = '0; st_m = '0; st_w = '0; exp_ill = 1'b0;
    endtask

    task automatic check_cycle();
        ctl_t dc;
        bit   ur, lw, raw, pc, hz;
        dc  = spec_ctl(d.op, d.fn);
        ur  = (d.op == 6'b000000) || (d.op == 6'b101011) || (d.op == 6'b000100);
        lw  = st_e.c.m2r && st_e.c.rw && (st_e.rt != 5'd0) && ((st_e.rt == d.rs) || (st_e.rt == d.rt));
        raw = 1'b0;
`ifndef FORWARDING_EN
        raw = hit(st_e, d, ur) || hit(st_m, d, ur) || hit(st_w, d, ur);
`endif
        pc  = st_m.c.br && st_m.zero;
        hz  = lw || raw;
        check("RegDstE",     32'(RegDstE),     32'(st_e.c.dst));
        check("ALUSrcE",     32'(ALUSrcE),     32'(st_e.c.src));
        check("ALUControlE", 32'(ALUControlE), 32'(st_e.c.alu));
        check("MemWriteM",   32'(MemWriteM),   32'(st_m.c.mw));
        check("PCSrcM",      32'(PCSrcM),      32'(pc));
        check("RegWriteW",   32'(RegWriteW),   32'(st_w.c.rw));
        check("MemToRegW",   32'(MemToRegW),   32'(st_w.c.m2r));
        check("StallF",      32'(StallF),      32'(hz && !pc));
        check("StallD",      32'(StallD),      32'(hz && !pc));
        check("FlushD",      32'(FlushD),      32'(pc));
        check("FlushE",      32'(FlushE),      32'(hz || pc));
        check("IllegalOp",   32'(IllegalOp),   32'(exp_ill));
`ifdef FORWARDING_EN
        check("ForwardAE",   32'(ForwardAE),   32'(fwd_exp(st_e.rs)));
        check("ForwardBE",   32'(ForwardBE),   32'(fwd_exp(st_e.rt)));
`endif
        $display("cyc=%0d D op=%b fn=%b rs=%0d rt=%0d stall=%0b flushD=%0b flushE=%0b",
                 cyc, d.op, d.fn, d.rs, d.rt, hz && !pc, pc, hz || pc);
        nx_stall  = hz && !pc;
        nx_pcsrc  = pc;
        nx_flushe = hz || pc;
        if (dc.ill) exp_ill = 1'b1;
    endtask

    task automatic advance();
        stage_t ne;
        st_w = st_m;
        st_m = nx_pcsrc ? stage_t'(0) : st_e;
        ne   = '0;
        if (!nx_flushe) begin
            ne.c    = spec_ctl(d.op, d.fn);
            ne.rs   = d.rs;
            ne.rt   = d.rt;
            ne.dest = ne.c.dst ? d.rd : d.rt;
            ne.zero = (d.rs == d.rt) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        st_e = ne;
        if (!nx_stall) d = next_instr();
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        advance();
        drive();
        cyc++;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_outs"}, 32'({RegDstE, ALUSrcE, ALUControlE, MemWriteM, PCSrcM, RegWriteW,
                                  MemToRegW, StallF, StallD, FlushD, FlushE}), 32'd0);
        check({tag, "_ill"}, 32'(IllegalOp), 32'd0);
`ifdef FORWARDING_EN
        check({tag, "_fwd"}, 32'({ForwardAE, ForwardBE}), 32'd0);
`endif
    endtask

    initial begin
        int guard;
        reset  = 1'b1;
        rnd_en = 1'b0;
        d      = filler();
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive();

        // add $3,$1,$2
        pend.push_back(mk(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3));
        repeat (5) tick();
        // lw $2,0($0) ; add $4,$2,$2
        pend.push_back(mk(6'b100011, 6'b000000, 5'd0, 5'd2, 5'd0));
        pend.push_back(mk(6'b000000, 6'b100000, 5'd2, 5'd2, 5'd4));
        repeat (8) tick();
        // beq $1,$1 then wrong-path sw/addi/add
        pend.push_back(mk(6'b000100, 6'b000000, 5'd1, 5'd1, 5'd0));
        pend.push_back(mk(6'b101011, 6'b000000, 5'd0, 5'd1, 5'd0));
        pend.push_back(mk(6'b001000, 6'b000000, 5'd0, 5'd3, 5'd0));
        pend.push_back(mk(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd5));
        repeat (8) tick();
        // add $3 ; sub $5,$3,$1 back-to-back, then with one gap
        pend.push_back(mk(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3));
        pend.push_back(mk(6'b000000, 6'b100010, 5'd3, 5'd1, 5'd5));
        pend.push_back(mk(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3));
        pend.push_back(filler());
        pend.push_back(mk(6'b000000, 6'b100010, 5'd3, 5'd1, 5'd5));
        repeat (12) tick();

        rnd_en = 1'b1;
        repeat (300) tick();
        rnd_en = 1'b0;

        // undefined opcode: sticky until reset
        pend.push_back(mk(6'b111111, 6'b000000, 5'd0, 5'd0, 5'd0));
        repeat (8) tick();

        // async reset with a load sitting in M
        pend.push_back(mk(6'b100011, 6'b000000, 5'd0, 5'd2, 5'd0));
        guard = 0;
        while (!st_m.c.m2r && guard < 10) begin
            tick();
            guard++;
        end
        check("lw_reached_m", 32'(st_m.c.m2r), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        @(negedge clk);
        check("rst_MemWriteM", 32'(MemWriteM), 32'd0);
        @(posedge clk);
        #1;
        check("rst_MemWriteM_edge", 32'(MemWriteM), 32'd0);
        check("rst_RegWriteW_edge", 32'(RegWriteW), 32'd0);
        reset = 1'b0;
        clear_model();
        drive();

        rnd_en = 1'b1;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
